// File: rtl/sequence_detector.sv
// sequence_detector: serial bit-pattern detector.
// Shifts one bit per rising clk edge into a LEN-bit history and pulses `out`
// for one cycle whenever the full history equals PATTERN. OVERLAP selects
// whether the bits of a match may be reused by the next match.
// Optional saturating match counter: define SEQ_DET_COUNT_EN.
module sequence_detector #(
    parameter int unsigned    LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b1101,
    parameter int unsigned    OVERLAP = 1,
    parameter int unsigned    CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    output logic             out
`ifdef SEQ_DET_COUNT_EN
    ,
    output logic [CNT_W-1:0] match_count
`endif
);

    localparam int unsigned       FILL_W = $clog2(LEN + 1);
    localparam logic [FILL_W-1:0] FULL   = FILL_W'(LEN);

    logic [LEN-1:0]    r_hist;
    logic [FILL_W-1:0] r_fill;
    logic              r_out;

    logic [LEN-1:0]    w_hist_next;
    logic [FILL_W-1:0] w_fill_next;
    logic              w_match;

    // Post-shift history/fill and the match decision taken on those values
    always_comb begin
        w_hist_next = {r_hist[LEN-2:0], in};
        w_fill_next = (r_fill == FULL) ? FULL : r_fill + 1'b1;
        w_match     = (w_fill_next == FULL) && (w_hist_next == PATTERN);
    end

    // History, fill level and registered match pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hist <= '0;
            r_fill <= '0;
            r_out  <= 1'b0;
        end else begin
            r_hist <= w_hist_next;
            // Without overlap a match empties the history so none of its
            // bits can contribute to the next match.
            if (w_match && (OVERLAP == 0)) begin
                r_fill <= '0;
            end else begin
                r_fill <= w_fill_next;
            end
            r_out <= w_match;
        end
    end

    assign out = r_out;

`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] r_count;

    // Saturating count of matches
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_match && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign match_count = r_count;
`endif

endmodule

// File: tb/tb_sequence_detector.sv
// tb_sequence_detector: scoreboard bench for sequence_detector.
// Three instances share the stream: 1101 with overlap, 1101 without overlap,
// and 11 (LEN=2, CNT_W=2) with overlap.
module tb_sequence_detector;

    typedef struct packed {
        logic ovl;
        logic novl;
        logic p11;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic in;
    logic out_ovl, out_novl, out_p11;
`ifdef SEQ_DET_COUNT_EN
    logic [7:0] cnt_ovl, cnt_novl;
    logic [1:0] cnt_p11;
`endif

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    logic have_prev = 1'b0;
    logic prev_bit  = 1'b0;

    always #5 clk = ~clk;

    sequence_detector #(.LEN(4), .PATTERN(4'b1101), .OVERLAP(1), .CNT_W(8)) dut_ovl (
        .clk(clk), .reset(reset), .in(in), .out(out_ovl)
`ifdef SEQ_DET_COUNT_EN
        , .match_count(cnt_ovl)
`endif
    );

    sequence_detector #(.LEN(4), .PATTERN(4'b1101), .OVERLAP(0), .CNT_W(8)) dut_novl (
        .clk(clk), .reset(reset), .in(in), .out(out_novl)
`ifdef SEQ_DET_COUNT_EN
        , .match_count(cnt_novl)
`endif
    );

    sequence_detector #(.LEN(2), .PATTERN(2'b11), .OVERLAP(1), .CNT_W(2)) dut_p11 (
        .clk(clk), .reset(reset), .in(in), .out(out_p11)
`ifdef SEQ_DET_COUNT_EN
        , .match_count(cnt_p11)
`endif
    );

    // Drive one bit, push its expected outputs, land 1 ns after the sampling edge.
    // The 11-pattern expectation is simply "this bit and the previous one are 1".
    task automatic send(input logic b, input logic e_ovl, input logic e_novl);
        exp_t e;
        @(negedge clk);
        in     = b;
        e.ovl  = e_ovl;
        e.novl = e_novl;
        e.p11  = have_prev && prev_bit && b;
        sb.push_back(e);
        have_prev = 1'b1;
        prev_bit  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset     = 1'b1;
        in        = 1'bx;
        have_prev = 1'b0;
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [3:0] bits;
        logic [3:0] hit;
        reset = 1'b1;
        in    = 1'bx;
        #10;
        checks++;
        if ({out_ovl, out_novl, out_p11} !== 3'b000) begin
            errors++;
            $display("FAIL reset_out: outs=%b expected 000", {out_ovl, out_novl, out_p11});
        end
`ifdef SEQ_DET_COUNT_EN
        checks++;
        if ({cnt_ovl, cnt_novl, cnt_p11} !== 18'd0) begin
            errors++;
            $display("FAIL reset_count: counts=%0d/%0d/%0d expected 0", cnt_ovl, cnt_novl, cnt_p11);
        end
`endif
        reset = 1'b0;
        bits = 4'b1101;
        hit  = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            send(bits[3-i], hit[3-i], hit[3-i]);
            e = sb.pop_front();
            checks++;
            if ({out_ovl, out_novl, out_p11} !== e) begin
                errors++;
                $display("FAIL first_match bit %0d: outs=%b expected %b", i + 1, {out_ovl, out_novl, out_p11}, e);
            end
        end
`ifdef SEQ_DET_COUNT_EN
        checks++;
        if (cnt_ovl !== 8'd1) begin
            errors++;
            $display("FAIL first_count: match_count=%0d expected 1", cnt_ovl);
        end
`endif
        send(1'b0, 1'b0, 1'b0);
        e = sb.pop_front();
        checks++;
        if ({out_ovl, out_novl, out_p11} !== e) begin
            errors++;
            $display("FAIL pulse_drop: outs=%b expected %b", {out_ovl, out_novl, out_p11}, e);
        end
    endtask

    task automatic test_stream();
        exp_t e;
        logic [0:29] bits;
        int n_ovl = 0;
        int n_novl = 0;
        bits = 30'b110110011010101100110011011010;
        apply_reset();
        for (int i = 0; i < 30; i++) begin
            int k;
            k = i + 1;
            send(bits[i], (k == 4 || k == 11 || k == 26 || k == 29),
                          (k == 4 || k == 11 || k == 26));
            e = sb.pop_front();
            checks++;
            if ({out_ovl, out_novl, out_p11} !== e) begin
                errors++;
                $display("FAIL stream bit %0d: outs=%b expected %b", k, {out_ovl, out_novl, out_p11}, e);
            end
            if (out_ovl === 1'b1) n_ovl++;
            if (out_novl === 1'b1) n_novl++;
        end
        checks++;
        if (n_ovl != 4 || n_novl != 3) begin
            errors++;
            $display("FAIL stream_pulses: overlap=%0d no_overlap=%0d expected 4 and 3", n_ovl, n_novl);
        end
`ifdef SEQ_DET_COUNT_EN
        checks++;
        if (cnt_ovl !== 8'd4 || cnt_novl !== 8'd3) begin
            errors++;
            $display("FAIL stream_count: counts=%0d/%0d expected 4/3", cnt_ovl, cnt_novl);
        end
`endif
    endtask

    task automatic test_async_reset();
        exp_t e;
        logic [3:0] bits;
        logic [3:0] hit;
        apply_reset();
        bits = 4'b1101;
        hit  = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            send(bits[3-i], hit[3-i], hit[3-i]);
            e = sb.pop_front();
            checks++;
            if ({out_ovl, out_novl, out_p11} !== e) begin
                errors++;
                $display("FAIL pre_reset bit %0d: outs=%b expected %b", i + 1, {out_ovl, out_novl, out_p11}, e);
            end
        end
        // out is high here; reset between edges must clear it at once
        #2;
        reset = 1'b1;
        in    = 1'bx;
        #1;
        checks++;
        if ({out_ovl, out_novl, out_p11} !== 3'b000) begin
            errors++;
            $display("FAIL async_clear: outs=%b expected 000", {out_ovl, out_novl, out_p11});
        end
        reset     = 1'b0;
        have_prev = 1'b0;
        // partial 1,1,0 then a mid-cycle reset; a following 1 must not match
        bits = 4'b1100;
        for (int i = 0; i < 3; i++) begin
            send(bits[3-i], 1'b0, 1'b0);
            e = sb.pop_front();
            checks++;
            if ({out_ovl, out_novl, out_p11} !== e) begin
                errors++;
                $display("FAIL partial bit %0d: outs=%b expected %b", i + 1, {out_ovl, out_novl, out_p11}, e);
            end
        end
        #2;
        reset = 1'b1;
        in    = 1'bx;
        #1;
        reset     = 1'b0;
        have_prev = 1'b0;
        bits = 4'b1110;
        hit  = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            send(bits[3-i], hit[3-i], hit[3-i]);
            e = sb.pop_front();
            checks++;
            if ({out_ovl, out_novl, out_p11} !== e) begin
                errors++;
                $display("FAIL post_reset bit %0d: outs=%b expected %b", i + 1, {out_ovl, out_novl, out_p11}, e);
            end
        end
        send(1'b1, 1'b1, 1'b1);
        e = sb.pop_front();
        checks++;
        if ({out_ovl, out_novl, out_p11} !== e) begin
            errors++;
            $display("FAIL post_reset_match: outs=%b expected %b", {out_ovl, out_novl, out_p11}, e);
        end
    endtask

    task automatic test_zeros_ones();
        exp_t e;
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            send((i >= 20), 1'b0, 1'b0);
            e = sb.pop_front();
            checks++;
            if ({out_ovl, out_novl, out_p11} !== e) begin
                errors++;
                $display("FAIL zeros_ones bit %0d: outs=%b expected %b", i + 1, {out_ovl, out_novl, out_p11}, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            send(1'b1, 1'b0, 1'b0);
            e = sb.pop_front();
            checks++;
            if ({out_ovl, out_novl, out_p11} !== e) begin
                errors++;
                $display("FAIL back_to_back bit %0d: outs=%b expected %b", i + 1, {out_ovl, out_novl, out_p11}, e);
            end
        end
`ifdef SEQ_DET_COUNT_EN
        checks++;
        if (cnt_p11 !== 2'd3) begin
            errors++;
            $display("FAIL count_saturate: match_count=%0d expected 3", cnt_p11);
        end
`endif
        send(1'b0, 1'b0, 1'b0);
        e = sb.pop_front();
        checks++;
        if ({out_ovl, out_novl, out_p11} !== e) begin
            errors++;
            $display("FAIL back_to_back_end: outs=%b expected %b", {out_ovl, out_novl, out_p11}, e);
        end
`ifdef SEQ_DET_COUNT_EN
        checks++;
        if (cnt_p11 !== 2'd3) begin
            errors++;
            $display("FAIL count_hold: match_count=%0d expected 3", cnt_p11);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_async_reset();
        test_zeros_ones();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sequence_detector.md
# sequence_detector

Serial bit-pattern detector. It samples a 1-bit serial stream `in` on every rising `clk` edge and pulses `out` high for one cycle each time the last `LEN` sampled bits equal `PATTERN`. The default pattern is `1101`, detected with overlap. It sits downstream of a serial receiver or framing front end and flags sync/marker words to control logic.

## Interface
- `PATTERN`, default `4'b1101`: target bit sequence. The MSB is the first bit received, the LSB the last.
- `LEN`, default `4`: pattern length in bits. Legal range 2–16.
- `OVERLAP`, default `1`:
  - `1` means the tail of a match may begin the next match.
  - `0` means a match consumes all of its bits.
- `CNT_W`, default `8`: width of the match counter.
- `clk`, input, 1: clock. All sampling is on the rising edge.
- `reset`, input, 1: reset. **One clock; reset is asynchronous and active-high.**
- `in`, input, 1: serial data bit, sampled each rising edge.
- `out`, output, 1: registered match pulse.
- `match_count`, output, `CNT_W`: saturating count of matches. Present only when `SEQ_DET_COUNT_EN` is defined.

## Operation
- Internal state:
  - `hist[LEN-1:0]` shift register; each new bit enters at the LSB.
  - `fill` counter, 0..`LEN`, giving the number of valid history bits.
- Each rising edge (not in reset):
  - `hist <= {hist[LEN-2:0], in}`.
  - `fill <= min(fill+1, LEN)`.
- Match condition: `fill_next == LEN` and `hist_next == PATTERN`, both evaluated on the post-shift values.
- On a match:
  - `out <= 1`.
  - If `OVERLAP=0`, `fill <= 0`, so no bit of this match is reused.
  - If `OVERLAP=1`, `fill` stays at `LEN`.
- No match: `out <= 0`.
- Bits sampled before `fill` reaches `LEN` never produce a match, so a partial history after reset cannot false-trigger.
- `in` is X or Z while `reset` is high: it is ignored, and no state is updated during reset.
- Reset values: `hist=0`, `fill=0`, `out=0`, `match_count=0`.
- Reset asserted mid-pattern: all partial progress is discarded. After release, a full `LEN` fresh bits are required before a match.
- Patterns with self-overlap are handled by construction, for example `1101` followed by `101` yields two matches. No separate fallback table is needed.

## Timing
- Latency: `out` rises on the same clock edge that samples the final pattern bit. It is high for exactly one cycle, then drops at the next edge unless another match completes there.
- Back-to-back matches produce consecutive high cycles. For example, `PATTERN=11`, `OVERLAP=1`, with `in` held at 1, keeps `out` high continuously after the second bit.
- Reset:
  - Assertion clears `out` immediately, without waiting for a clock edge.
  - Deassertion takes effect at the first rising edge with `reset` low. That edge samples bit 0 of the stream.
- `out` is glitch-free: it is driven only from a flop.

## Configuration
- `SEQ_DET_COUNT_EN`:
  - Defined: the `match_count` port and counter exist. The counter increments by 1 on each cycle where `out` goes or stays high due to a match. It saturates at `2^CNT_W-1` with no wrap, and clears on reset.
  - Undefined: the port and counter logic are absent, and `out` behaviour is identical.

## Test plan
- Reset high for 10 ns, then in = 1,1,0,1 on successive edges: `out` is 1 only in the cycle after the 4th sample. `match_count=1`.
- Stream 1,1,0,1,1,0,0,1,1,0,1,0,1,0,1,1,0,0,1,1,0,0,1,1,0,1,1,0,1,0: `out` pulses exactly 4 times, after bits 4, 11, 26 and 29. The 26/29 pair checks overlap.
- Same stream with `OVERLAP=0`: pulses after bits 4, 11 and 26 only. The match at bit 29 is suppressed.
- Send 1,1,0, then assert `reset` asynchronously between edges and release, then send 1: no pulse, and `out` goes to 0 immediately on reset. A following 1,1,0,1 pulses once.
- With `SEQ_DET_COUNT_EN`, `CNT_W=2` and 5 matches: `match_count` reads 3 and holds.
- `in` all zeros for 20 cycles, then all ones for 20 cycles: `out` never asserts.
